// File: rtl/idli_fetch_m.sv
// SQI instruction fetch: issues a sequential quad READ and streams instruction nibbles to the decoder.
// Build option: define IDLI_SQI_DUMMY_EN to insert two dummy turnaround cycles before read data.
//
// state  | meaning
// IDLE   | chip select high for one cycle, clock gated
// CMD0   | drive high nibble of READ opcode (0x0)
// CMD1   | drive low nibble of READ opcode (0x3)
// ADDR3  | drive pc[15:12]
// ADDR2  | drive pc[11:8]
// ADDR1  | drive pc[7:4]
// ADDR0  | drive pc[3:0]
// DUMMY0 | turnaround cycle 1 (IDLI_SQI_DUMMY_EN only)
// DUMMY1 | turnaround cycle 2 (IDLI_SQI_DUMMY_EN only)
// DATA   | sequential read, one instruction nibble per clocked cycle
module idli_fetch_m (
   input  logic        i_fetch_gck,
   input  logic        i_fetch_rst,
   input  logic        i_fetch_redirect,
   input  logic [15:0] i_fetch_redirect_pc,
   input  logic        i_fetch_stall,
   input  logic [3:0]  i_sqi_sio,
   output logic [3:0]  o_sqi_sio,
   output logic        o_sqi_sio_oe,
   output logic        o_sqi_cs_n,
   output logic        o_sqi_sck_en,
   output logic [3:0]  o_fetch_enc,
   output logic        o_fetch_enc_vld,
   output logic [15:0] o_fetch_pc
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD0,
      ST_CMD1,
      ST_ADDR3,
      ST_ADDR2,
      ST_ADDR1,
      ST_ADDR0,
`ifdef IDLI_SQI_DUMMY_EN
      ST_DUMMY0,
      ST_DUMMY1,
`endif
      ST_DATA
   } state_t;

   state_t      state_q;
   logic [1:0]  nib_q;
   logic [15:0] pc_q;

   logic        in_data;
   logic        boundary_stall;
   logic        unused_redirect_lsb;

   // Instructions are halfword aligned, so the redirect LSB carries no information.
   assign unused_redirect_lsb = i_fetch_redirect_pc[0];

   assign in_data        = (state_q == ST_DATA);
   assign boundary_stall = in_data & (nib_q == 2'd0) & i_fetch_stall;

   always_comb begin
      o_sqi_sio    = 4'h0;
      o_sqi_sio_oe = 1'b0;
      o_sqi_cs_n   = 1'b0;
      o_sqi_sck_en = 1'b1;
      case (state_q)
         ST_IDLE: begin
            o_sqi_cs_n   = 1'b1;
            o_sqi_sck_en = 1'b0;
         end
         ST_CMD0: begin
            o_sqi_sio_oe = 1'b1;
         end
         ST_CMD1: begin
            o_sqi_sio    = 4'h3;
            o_sqi_sio_oe = 1'b1;
         end
         ST_ADDR3: begin
            o_sqi_sio    = pc_q[15:12];
            o_sqi_sio_oe = 1'b1;
         end
         ST_ADDR2: begin
            o_sqi_sio    = pc_q[11:8];
            o_sqi_sio_oe = 1'b1;
         end
         ST_ADDR1: begin
            o_sqi_sio    = pc_q[7:4];
            o_sqi_sio_oe = 1'b1;
         end
         ST_ADDR0: begin
            o_sqi_sio    = pc_q[3:0];
            o_sqi_sio_oe = 1'b1;
         end
         // Gating the SQI clock freezes the memory's read pointer during a stall.
         ST_DATA: begin
            o_sqi_sck_en = ~boundary_stall;
         end
         default: begin
         end
      endcase
   end

   assign o_fetch_enc     = i_sqi_sio;
   assign o_fetch_enc_vld = in_data & o_sqi_sck_en & ~i_fetch_redirect;
   assign o_fetch_pc      = pc_q;

   always_ff @(posedge i_fetch_gck) begin
      if (i_fetch_rst) begin
         state_q <= ST_IDLE;
         nib_q   <= 2'd0;
         pc_q    <= 16'h0000;
      end else if (i_fetch_redirect) begin
         state_q <= ST_IDLE;
         nib_q   <= 2'd0;
         pc_q    <= {i_fetch_redirect_pc[15:1], 1'b0};
      end else begin
         case (state_q)
            ST_IDLE:  state_q <= ST_CMD0;
            ST_CMD0:  state_q <= ST_CMD1;
            ST_CMD1:  state_q <= ST_ADDR3;
            ST_ADDR3: state_q <= ST_ADDR2;
            ST_ADDR2: state_q <= ST_ADDR1;
            ST_ADDR1: state_q <= ST_ADDR0;
`ifdef IDLI_SQI_DUMMY_EN
            ST_ADDR0:  state_q <= ST_DUMMY0;
            ST_DUMMY0: state_q <= ST_DUMMY1;
            ST_DUMMY1: state_q <= ST_DATA;
`else
            ST_ADDR0:  state_q <= ST_DATA;
`endif
            // Memory wraps at 64K just like the PC, so the stream never restarts.
            ST_DATA: begin
               if (o_fetch_enc_vld) begin
                  nib_q <= nib_q + 2'd1;
                  if (nib_q == 2'd3) begin
                     pc_q <= pc_q + 16'd2;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
